// File: rtl/ram512_arbiter_pkg.sv
// Shared types and default sizes for the RAM512 arbiter.
package ram_arb_pkg;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;
  localparam logic [7:0] CLR_VAL = 8'h00;

  typedef enum logic {IDLE, CLEAR} arb_state_t;
  typedef enum logic {PORT_A, PORT_B} port_id_t;

  // One read-return pipeline slot: who gets the data when it comes back.
  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_stage_t;
endpackage

// File: rtl/ram512_arbiter_if.sv
// Requester A/B handshakes plus the RAM512 control/data bus.
interface ram512_arbiter_if #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W
);
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata, b_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_rdata,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_rdata,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram512_arbiter_rr_arb2.sv
// Two-input round-robin picker; on a tie the port not granted last wins.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_gnt,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == PORT_A) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end
endmodule

// File: rtl/ram512_arbiter.sv
// Shares RAM512 between ports A and B with round-robin grants, a fixed
// two-cycle read return, and a full-depth clear engine.
module ram512_arbiter #(
  parameter int ADDR_W = ram_arb_pkg::ADDR_W,
  parameter int DATA_W = ram_arb_pkg::DATA_W,
  parameter int DEPTH  = ram_arb_pkg::DEPTH,
  parameter logic [DATA_W-1:0] CLR_VAL = ram_arb_pkg::CLR_VAL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_start,
  output logic clr_busy,
  ram512_arbiter_if.slave bus
);
  import ram_arb_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  arb_state_t        state_q, state_d;
  port_id_t          last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  rd_stage_t [1:0]   rd_pipe_q, rd_pipe_d;
  logic [1:0]        pick, gnt;

  rr_arb2 u_arb (
    .req      ({bus.b_req, bus.a_req}),
    .last_gnt (last_gnt_q),
    .gnt      (pick)
  );

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    cnt_d       = cnt_q;
    gnt         = 2'b00;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rd_pipe_d[1] = rd_pipe_q[0];
    rd_pipe_d[0] = '{valid: 1'b0, port: PORT_A};
    case (state_q)
      IDLE: begin
        // A clear request pre-empts any grant in the same cycle.
        if (clr_start) begin
          state_d = CLEAR;
        end else if (|pick) begin
          gnt          = pick;
          last_gnt_d   = pick[1] ? PORT_B : PORT_A;
          ram_en_d     = 1'b1;
          ram_we_d     = pick[1] ? bus.b_we    : bus.a_we;
          ram_addr_d   = pick[1] ? bus.b_addr  : bus.a_addr;
          ram_wdata_d  = pick[1] ? bus.b_wdata : bus.a_wdata;
          rd_pipe_d[0] = '{valid: !ram_we_d, port: last_gnt_d};
        end
      end
      CLEAR: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = cnt_q[ADDR_W-1:0];
        ram_wdata_d = CLR_VAL;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_gnt_q  <= PORT_B;
      cnt_q       <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      cnt_q       <= cnt_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign clr_busy      = (state_q == CLEAR);
  assign bus.a_gnt     = gnt[0];
  assign bus.b_gnt     = gnt[1];
  assign bus.a_rvalid  = rd_pipe_q[1].valid && (rd_pipe_q[1].port == PORT_A);
  assign bus.b_rvalid  = rd_pipe_q[1].valid && (rd_pipe_q[1].port == PORT_B);
  assign bus.a_rdata   = bus.ram_rdata;
  assign bus.b_rdata   = bus.ram_rdata;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
endmodule

// File: tb/tb_ram512_arbiter.sv
// Directed bench for ram512_arbiter with a behavioural RAM512 behind it.
module tb_ram512_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_start = 1'b0;
  logic clr_busy;
  logic mem_init = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ram512_arbiter_if bus ();

  ram512_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // RAM512 model: registered read data, writes do not update rdata.
  logic [7:0] mem [512];
  logic [7:0] rd_q = 8'h00;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h80 | {1'b0, i[6:0]};
    end else if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            rd_q <= mem[bus.ram_addr];
    end
  end
  assign bus.ram_rdata = rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One access on one port, assuming the other port is idle.
  task automatic single(input bit pb, input bit we, input logic [8:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
    @(posedge clk); #1;
    if (pb) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    @(negedge clk);
    chk({tag, ".gnt"},   pb ? bus.b_gnt : bus.a_gnt, 1);
    chk({tag, ".ogn"},   pb ? bus.a_gnt : bus.b_gnt, 0);
    @(posedge clk); #1;
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    @(negedge clk);
    chk({tag, ".en"},    bus.ram_en, 1);
    chk({tag, ".we"},    bus.ram_we, we);
    chk({tag, ".addr"},  bus.ram_addr, addr);
    if (we) chk({tag, ".wdata"}, bus.ram_wdata, wd);
    chk({tag, ".rv1"},   {bus.b_rvalid, bus.a_rvalid}, 0);
    @(negedge clk);
    chk({tag, ".rv2"},   {bus.b_rvalid, bus.a_rvalid}, we ? 2'b00 : (pb ? 2'b10 : 2'b01));
    if (!we) chk({tag, ".rdata"}, pb ? bus.b_rdata : bus.a_rdata, exp_rd);
    chk({tag, ".en_off"}, bus.ram_en, 0);
    chk({tag, ".ahold"}, bus.ram_addr, addr);
    @(negedge clk);
    chk({tag, ".rv3"},   {bus.b_rvalid, bus.a_rvalid}, 0);
  endtask

  // Runs from the cycle after clr_start until clr_busy falls; optionally
  // re-pulses clr_start when the counter is at pulse_at.
  task automatic clear_sweep(input int pulse_at, output int busy, output int good, output int bad);
    busy = 0; good = 0; bad = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      clr_start = (busy == pulse_at);
      @(negedge clk);
      if (!clr_busy) break;
      if (busy > 0 && bus.ram_en && bus.ram_we && bus.ram_addr == 9'(busy - 1) &&
          bus.ram_wdata == CLR_VAL) good++;
      if (bus.a_gnt || bus.b_gnt) bad++;
      busy++;
    end
    clr_start = 1'b0;
    if (bus.ram_en && bus.ram_we && bus.ram_addr == 9'h1FF) good++;
  endtask

  initial begin
    int busy, good, bad, nz, hit;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.en",    bus.ram_en, 0);
    chk("rst.we",    bus.ram_we, 0);
    chk("rst.addr",  bus.ram_addr, 0);
    chk("rst.wdata", bus.ram_wdata, 0);
    chk("rst.rv",    {bus.b_rvalid, bus.a_rvalid}, 0);
    chk("rst.busy",  clr_busy, 0);
    @(posedge clk); #1;
    mem_init = 1'b0;
    rst_n = 1'b1;

    single(1'b0, 1'b1, 9'h010, 8'hA5, 8'h00, "t1");
    single(1'b1, 1'b0, 9'h010, 8'h00, 8'hA5, "t2");

    // Both ports read continuously; B was granted last so A leads.
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      bus.a_req = (c < 4); bus.a_we = 1'b0; bus.a_addr = 9'h010;
      bus.b_req = (c < 4); bus.b_we = 1'b0; bus.b_addr = 9'h020;
      @(negedge clk);
      chk("rr.agnt", bus.a_gnt, (c < 4) && (c % 2 == 0));
      chk("rr.bgnt", bus.b_gnt, (c < 4) && (c % 2 == 1));
      chk("rr.en",   bus.ram_en, (c >= 1) && (c <= 4));
      chk("rr.arv",  bus.a_rvalid, (c == 2) || (c == 4));
      chk("rr.brv",  bus.b_rvalid, (c == 3) || (c == 5));
      if (bus.a_rvalid) chk("rr.ard", bus.a_rdata, 8'hA5);
      if (bus.b_rvalid) chk("rr.brd", bus.b_rdata, 8'hA0);
    end

    // Clear with A's write pending.
    @(posedge clk); #1;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 9'h030; bus.a_wdata = 8'h77;
    clr_start = 1'b1;
    @(negedge clk);
    chk("clr.nogn", bus.a_gnt, 0);
    chk("clr.busy0", clr_busy, 0);
    clear_sweep(-1, busy, good, bad);
    chk("clr.cycles", busy, 512);
    chk("clr.writes", good, 512);
    chk("clr.gnt_in", bad, 0);
    chk("clr.agnt",  bus.a_gnt, 1);
    @(posedge clk); #1;
    bus.a_req = 1'b0;
    @(negedge clk);
    chk("clr.waddr", bus.ram_addr, 9'h030);
    chk("clr.wdat",  bus.ram_wdata, 8'h77);
    @(negedge clk);
    nz = 0;
    for (int i = 0; i < 512; i++) if (i != 'h30 && mem[i] != 8'h00) nz++;
    chk("clr.nonzero", nz, 0);
    chk("clr.m30", mem[9'h030], 8'h77);
    single(1'b0, 1'b0, 9'h010, 8'h00, 8'h00, "clr.rd");

    // Read granted just before a clear still returns; then reset mid-clear.
    @(posedge clk); #1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 9'h030;
    @(negedge clk);
    chk("pre.gnt", bus.a_gnt, 1);
    @(posedge clk); #1;
    bus.a_req = 1'b0; clr_start = 1'b1;
    @(negedge clk);
    chk("pre.rv1", bus.a_rvalid, 0);
    @(posedge clk); #1;
    clr_start = 1'b0;
    @(negedge clk);
    chk("pre.busy", clr_busy, 1);
    chk("pre.rv2",  bus.a_rvalid, 1);
    chk("pre.rd",   bus.a_rdata, 8'h77);
    hit = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.ram_en && bus.ram_addr == 9'd200) begin hit = 1; break; end
    end
    chk("rst.hit200", hit, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", clr_busy, 0);
    chk("mrst.en",   bus.ram_en, 0);
    chk("mrst.we",   bus.ram_we, 0);
    chk("mrst.addr", bus.ram_addr, 0);
    chk("mrst.rv",   {bus.b_rvalid, bus.a_rvalid}, 0);

    // After reset A wins a tie again, even though A was granted last.
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 9'h010;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 9'h020;
    @(negedge clk);
    chk("tie.agnt", bus.a_gnt, 1);
    chk("tie.bgnt", bus.b_gnt, 0);
    chk("tie.busy", clr_busy, 0);
    @(posedge clk); #1;
    bus.a_req = 1'b0;
    @(negedge clk);
    chk("tie.bgnt2", bus.b_gnt, 1);
    @(posedge clk); #1;
    bus.b_req = 1'b0;
    @(negedge clk);
    chk("tie.arv", bus.a_rvalid, 1);
    chk("tie.ard", bus.a_rdata, 8'h00);
    @(negedge clk);
    chk("tie.brv", bus.b_rvalid, 1);

    // Fresh sweep from 0 with a stray clr_start at counter 100.
    @(posedge clk); #1;
    clr_start = 1'b1;
    @(negedge clk);
    chk("re.busy0", clr_busy, 0);
    clear_sweep(100, busy, good, bad);
    chk("re.cycles", busy, 512);
    chk("re.writes", good, 512);
    chk("re.gnt_in", bad, 0);
    @(negedge clk);
    @(negedge clk);
    chk("re.busy_end", clr_busy, 0);
    nz = 0;
    for (int i = 0; i < 512; i++) if (mem[i] != 8'h00) nz++;
    chk("re.nonzero", nz, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
